// File: rtl/fetch_sequencer.sv
// Fetch stage: owns PC and IR, muxes the memory address, splits instruction fields and gates
// execution for halt/single-step. Define FETCH_BREAKPOINT_EN to add a PC breakpoint compare.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [15:0]       mem_rdata,
    input  logic [ADDR_W-1:0] dat_addr,
    input  logic              insdat,
    input  logic              pc_en,
    input  logic              jump,
    input  logic              branch,
    input  logic              step_mode,
    input  logic              step_req,
    input  logic              resume,
`ifdef FETCH_BREAKPOINT_EN
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [4:0]        opcode,
    output logic [2:0]        func,
    output logic [2:0]        rd,
    output logic [2:0]        rs,
    output logic [2:0]        rt,
    output logic [7:0]        imm8,
    output logic              exe_en,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);
    typedef enum logic [1:0] {StRun, StStepIdle, StStepExec, StHalted} state_e;

    localparam logic [ADDR_W-1:0] PcOne = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, jump_pc, branch_pc;
    logic [15:0]       ir_q, word;
    logic [2:0]        sync_q;
    logic              boot_q, step_pulse, adv, halt_det, bp_hit, bp_resume;

    // In the data phase the fields come from IR so control sees a stable instruction.
    assign word     = insdat ? ir_q : mem_rdata;
    assign mem_addr = insdat ? dat_addr : pc_q;
    assign opcode   = word[15:11];
    assign func     = {1'b0, word[1:0]};
    assign rd       = word[10:8];
    assign rs       = word[7:5];
    assign rt       = word[4:2];
    assign imm8     = word[7:0];
    assign pc       = pc_q;
    assign halted   = (state_q == StHalted);

    assign step_pulse = sync_q[1] & ~sync_q[2];
    assign adv        = pc_en & exe_en;
    assign halt_det   = exe_en & ~insdat & (word[15:11] == 5'b11111);

`ifdef FETCH_BREAKPOINT_EN
    logic bp_halt_q, bp_skip_q;

    assign bp_hit    = (state_q == StRun) & bp_valid & ~insdat & (pc_q == bp_addr) & ~bp_skip_q;
    assign bp_resume = bp_halt_q;

    // bp_skip_q lets the instruction at the breakpoint run once after resume.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bp_halt_q <= 1'b0;
            bp_skip_q <= 1'b0;
        end else begin
            if (bp_hit) begin
                bp_halt_q <= 1'b1;
            end else if (state_q == StHalted && resume) begin
                bp_halt_q <= 1'b0;
            end
            if (state_q == StHalted && resume && bp_halt_q) begin
                bp_skip_q <= 1'b1;
            end else if (adv) begin
                bp_skip_q <= 1'b0;
            end
        end
    end
`else
    assign bp_hit    = 1'b0;
    assign bp_resume = 1'b0;
`endif

    // boot_q holds off execution for one cycle when step_mode is high out of reset.
    always_comb begin
        unique case (state_q)
            StRun:      exe_en = ~bp_hit & ~(boot_q & step_mode);
            StStepExec: exe_en = 1'b1;
            default:    exe_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (bp_hit || halt_det) begin
                    state_d = StHalted;
                end else if (step_mode && (adv || boot_q)) begin
                    state_d = StStepIdle;
                end
            end
            StStepIdle: begin
                if (step_pulse) begin
                    state_d = StStepExec;
                end else if (!step_mode) begin
                    state_d = StRun;
                end
            end
            StStepExec: begin
                if (halt_det) begin
                    state_d = StHalted;
                end else if (adv) begin
                    state_d = step_mode ? StStepIdle : StRun;
                end
            end
            StHalted: begin
                if (resume) begin
                    state_d = (step_mode && !bp_resume) ? StStepIdle : StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        jump_pc       = pc_q;
        jump_pc[12:0] = word[12:0];
        branch_pc     = pc_q + PcOne + {{(ADDR_W-8){word[7]}}, word[7:0]};
        pc_d          = pc_q;
        if (state_q == StHalted) begin
            if (resume && !bp_resume) begin
                pc_d = pc_q + PcOne;
            end
        end else if (adv && !halt_det) begin
            if (jump) begin
                pc_d = jump_pc;
            end else if (branch) begin
                pc_d = branch_pc;
            end else begin
                pc_d = pc_q + PcOne;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            sync_q  <= '0;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sync_q  <= {sync_q[1:0], step_req};
            boot_q  <= 1'b0;
            if (!insdat && (state_q == StRun || state_q == StStepExec)) begin
                ir_q <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against an arithmetic PC/IR model.
module tb_fetch_sequencer;
    logic        clock, reset_n;
    logic [15:0] mem_rdata, dat_addr;
    logic        insdat, pc_en, jump, branch, step_mode, step_req, resume;
    logic [15:0] mem_addr, pc;
    logic [4:0]  opcode;
    logic [2:0]  func, rd, rs, rt;
    logic [7:0]  imm8;
    logic        exe_en, halted;
`ifdef FETCH_BREAKPOINT_EN
    logic [15:0] bp_addr;
    logic        bp_valid;
    initial begin
        bp_addr  = '0;
        bp_valid = 1'b0;
    end
`endif

    int          n_chk, n_fail;
    logic [15:0] m_pc, m_ir;
    bit          got;

    fetch_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mem_rdata (mem_rdata),
        .dat_addr  (dat_addr),
        .insdat    (insdat),
        .pc_en     (pc_en),
        .jump      (jump),
        .branch    (branch),
        .step_mode (step_mode),
        .step_req  (step_req),
        .resume    (resume),
`ifdef FETCH_BREAKPOINT_EN
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
`endif
        .mem_addr  (mem_addr),
        .opcode    (opcode),
        .func      (func),
        .rd        (rd),
        .rs        (rs),
        .rt        (rt),
        .imm8      (imm8),
        .exe_en    (exe_en),
        .halted    (halted),
        .pc        (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Next PC from the architectural rules, using plain integer arithmetic.
    function automatic logic [15:0] next_pc(input logic [15:0] p, input logic [15:0] w,
                                            input bit j, input bit b);
        int off;
        if (j) return (p & 16'hE000) | (w & 16'h1FFF);
        if (b) begin
            off = int'(w[7:0]);
            if (off > 127) off -= 256;
            return 16'((int'(p) + 1 + off) & 32'hFFFF);
        end
        return 16'((int'(p) + 1) & 32'hFFFF);
    endfunction

    task automatic exec1(input logic [15:0] w, input bit j, input bit b);
        mem_rdata = w;
        insdat    = 1'b0;
        pc_en     = 1'b1;
        jump      = j;
        branch    = b;
        #1;
        chk("mem_addr", mem_addr, m_pc);
        chk("opcode_live", opcode, w[15:11]);
        tick();
        m_pc = next_pc(m_pc, w, j, b);
        m_ir = w;
        chk("pc", pc, m_pc);
        pc_en  = 1'b0;
        jump   = 1'b0;
        branch = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset_n = 1'b0; mem_rdata = 16'hFFFF; dat_addr = 16'h1234; insdat = 1'b1;
        pc_en = 1'b0; jump = 1'b0; branch = 1'b0;
        step_mode = 1'b0; step_req = 1'b0; resume = 1'b0;
        m_pc = 16'h0000; m_ir = 16'h0000;
        #3;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_exe_en", exe_en, 1'b1);
        chk("rst_halted", halted, 1'b0);
        chk("rst_ir", opcode, 5'd0);
        chk("rst_mem_addr_dat", mem_addr, 16'h1234);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Three ALU instructions back to back
        exec1(16'h0A41, 1'b0, 1'b0);
        exec1(16'h0B65, 1'b0, 1'b0);
        exec1(16'h0C8A, 1'b0, 1'b0);
        insdat = 1'b1; mem_rdata = 16'h0000;
        #1;
        chk("ir_rd", rd, m_ir[10:8]);
        chk("ir_rs", rs, m_ir[7:5]);
        chk("ir_rt", rt, m_ir[4:2]);
        chk("ir_func", func, {1'b0, m_ir[1:0]});
        chk("ir_imm8", imm8, m_ir[7:0]);

        // LDM: fetch phase then data phase
        exec1(16'h0010, 1'b1, 1'b0);
        mem_rdata = 16'h2A20; insdat = 1'b0; pc_en = 1'b0;
        #1;
        chk("ldm_addr_fetch", mem_addr, 16'h0010);
        chk("ldm_opcode_fetch", opcode, 5'b00101);
        tick();
        m_ir = 16'h2A20;
        chk("ldm_pc_hold", pc, m_pc);
        insdat = 1'b1; dat_addr = 16'h0200; mem_rdata = 16'hFFFF; pc_en = 1'b1;
        #1;
        chk("ldm_addr_data", mem_addr, 16'h0200);
        chk("ldm_opcode_data", opcode, 5'b00101);
        tick();
        m_pc = 16'h0011;
        chk("ldm_pc", pc, m_pc);
        pc_en = 1'b0;

        // Branch back by one, jump-over-branch priority, wrap through 0xFFFF
        exec1(16'h0020, 1'b1, 1'b0);
        exec1(16'h10FE, 1'b0, 1'b1);
        chk("branch_back", pc, 16'h001F);
        exec1(16'h0000, 1'b1, 1'b1);
        exec1(16'h10FE, 1'b0, 1'b1);
        chk("branch_to_ffff", pc, 16'hFFFF);
        exec1(16'h0A41, 1'b0, 1'b0);
        chk("wrap", pc, 16'h0000);

        // HLT at 0x0030
        exec1(16'h0030, 1'b1, 1'b0);
        mem_rdata = 16'hF800; insdat = 1'b0; pc_en = 1'b1;
        #1;
        chk("hlt_exe_before", exe_en, 1'b1);
        tick();
        chk("hlt_halted", halted, 1'b1);
        chk("hlt_exe_en", exe_en, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hlt_pc_hold", pc, 16'h0030);
        end
        mem_rdata = 16'h0000; pc_en = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0;
        m_pc = 16'h0031;
        chk("resume_pc", pc, m_pc);
        chk("resume_halted", halted, 1'b0);
        chk("resume_exe_en", exe_en, 1'b1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_ignored", pc, m_pc);

        // Single step: one instruction enters stepping, then pc frozen
        step_mode = 1'b1;
        exec1(16'h0A41, 1'b0, 1'b0);
        chk("step_idle_exe", exe_en, 1'b0);
        insdat = 1'b1; pc_en = 1'b1; mem_rdata = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("step_frozen_pc", pc, m_pc);
        end
        pc_en = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (exe_en) got = 1'b1;
        end
        chk("step_grant", got, 1'b1);
        // MUL: two cycles, with a second step edge arriving mid-instruction
        mem_rdata = 16'h4A4B; insdat = 1'b0; pc_en = 1'b0; step_req = 1'b1;
        tick();
        m_ir = 16'h4A4B;
        chk("mul_exe_c1", exe_en, 1'b1);
        step_req = 1'b0; insdat = 1'b1; mem_rdata = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mul_exe_hold", exe_en, 1'b1);
        end
        pc_en = 1'b1;
        tick();
        m_pc = next_pc(m_pc, m_ir, 1'b0, 1'b0);
        chk("mul_pc", pc, m_pc);
        chk("mul_done_exe", exe_en, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("step_no_queue_pc", pc, m_pc);
            chk("step_no_queue_exe", exe_en, 1'b0);
        end
        chk("step_ir_hold", opcode, m_ir[15:11]);
        pc_en = 1'b0; step_mode = 1'b0;
        tick();
        chk("step_exit_exe", exe_en, 1'b1);

        // Page-absolute jumps: climb to page 2
        exec1(16'h1FFF, 1'b1, 1'b0);
        exec1(16'h0A41, 1'b0, 1'b0);
        exec1(16'h1FFF, 1'b1, 1'b0);
        exec1(16'h0A41, 1'b0, 1'b0);
        exec1(16'h0005, 1'b1, 1'b0);
        chk("page_pc", pc, 16'h4005);
        exec1(16'h0100, 1'b1, 1'b0);
        chk("jump_page", pc, 16'h4100);

        // Randomized run phase
        for (int i = 0; i < 40; i++) begin
            logic [15:0] w, eff, da;
            bit d, pe, j, b;
            w = 16'($urandom);
            if (w[15:11] == 5'h1F) w[15] = 1'b0;
            da = 16'($urandom);
            d  = ($urandom_range(2) == 0);
            pe = 1'($urandom_range(1));
            j  = ($urandom_range(3) == 0);
            b  = ($urandom_range(3) == 0);
            eff = d ? m_ir : w;
            mem_rdata = w; dat_addr = da; insdat = d; pc_en = pe; jump = j; branch = b;
            #1;
            chk("rnd_mem_addr", mem_addr, d ? da : m_pc);
            chk("rnd_opcode", opcode, eff[15:11]);
            chk("rnd_imm8", imm8, eff[7:0]);
            tick();
            if (pe) m_pc = next_pc(m_pc, eff, j, b);
            if (!d) m_ir = w;
            chk("rnd_pc", pc, m_pc);
        end
        pc_en = 1'b0; jump = 1'b0; branch = 1'b0;

        // Reset in the data phase of STR
        mem_rdata = 16'h3123; insdat = 1'b0;
        tick();
        insdat = 1'b1; pc_en = 1'b1; dat_addr = 16'h0777;
        #2 reset_n = 1'b0;
        #1;
        m_pc = 16'h0000; m_ir = 16'h0000;
        chk("mid_rst_pc", pc, m_pc);
        chk("mid_rst_ir", opcode, 5'd0);
        chk("mid_rst_exe", exe_en, 1'b1);
        chk("mid_rst_halted", halted, 1'b0);
        tick();
        chk("in_rst_pc", pc, m_pc);
        pc_en = 1'b0; step_mode = 1'b1;
        reset_n = 1'b1;
        tick();
        chk("boot_step_exe", exe_en, 1'b0);
        chk("boot_step_pc", pc, m_pc);
        step_mode = 1'b0;
        tick();
        chk("boot_run_exe", exe_en, 1'b1);
        exec1(16'h0A41, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
